// File: rtl/frv_mem_arbiter.sv
// frv_mem_arbiter
//   Two-to-one arbiter sharing one memory bus between the instruction fetch
//   port (imem) and the load/store port (dmem). The chosen requester is held
//   (locked) until the bus grants it. Responses return in order and are routed
//   back to their issuer through a one-bit-per-entry owner FIFO.
//
//   Parameters : MAX_OUTSTANDING - granted-but-unanswered transactions (1..8,
//                power of two); this is also the owner FIFO depth.
//   Build macro: FRV_MEM_ARBITER_ROUND_ROBIN_EN - when defined, unlocked
//                arbitration alternates between requesters. When undefined,
//                dmem has fixed priority over imem.
//
//   Ports:
//     g_clk, g_reset             clock, synchronous active-high reset
//     imem_* / dmem_*            requester side: req/wen/strb/addr/wdata in,
//                                gnt/recv/error/rdata out, ack in
//     bus_*                      shared side: req/wen/strb/addr/wdata/ack out,
//                                gnt/recv/error/rdata in
module frv_mem_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        g_clk,
    input  logic        g_reset,

    input  logic        imem_req,
    input  logic        imem_wen,
    input  logic [3:0]  imem_strb,
    input  logic [31:0] imem_addr,
    input  logic [31:0] imem_wdata,
    output logic        imem_gnt,
    output logic        imem_recv,
    input  logic        imem_ack,
    output logic        imem_error,
    output logic [31:0] imem_rdata,

    input  logic        dmem_req,
    input  logic        dmem_wen,
    input  logic [3:0]  dmem_strb,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic        dmem_gnt,
    output logic        dmem_recv,
    input  logic        dmem_ack,
    output logic        dmem_error,
    output logic [31:0] dmem_rdata,

    output logic        bus_req,
    output logic        bus_wen,
    output logic [3:0]  bus_strb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_recv,
    output logic        bus_ack,
    input  logic        bus_error,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic {
        OWN_IMEM = 1'b0,
        OWN_DMEM = 1'b1
    } owner_t;

    // State
    logic             lock_valid_q;
    owner_t           lock_owner_q;
    owner_t           fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
`ifdef FRV_MEM_ARBITER_ROUND_ROBIN_EN
    owner_t           rr_pref_q;
`endif

    // Combinational
    owner_t           owner;
    owner_t           head_owner;
    logic             sel_req;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             cap_ok;
    logic [PTR_W-1:0] head_nxt;
    logic [PTR_W-1:0] tail_nxt;

    // Owner selection and request forwarding
    always_comb begin
        owner = OWN_IMEM;
        if (lock_valid_q) begin
            owner = lock_owner_q;
        end else begin
`ifdef FRV_MEM_ARBITER_ROUND_ROBIN_EN
            if (imem_req && dmem_req)
                owner = rr_pref_q;
            else
                owner = dmem_req ? OWN_DMEM : OWN_IMEM;
`else
            owner = dmem_req ? OWN_DMEM : OWN_IMEM;
`endif
        end

        sel_req = (owner == OWN_DMEM) ? dmem_req : imem_req;

        // A same-cycle pop frees a slot, so a full FIFO still admits a request.
        cap_ok  = (count_q < CNT_W'(MAX_OUTSTANDING)) || pop;
        bus_req = lock_valid_q ? sel_req : (sel_req && cap_ok);

        bus_wen   = (owner == OWN_DMEM) ? dmem_wen   : imem_wen;
        bus_strb  = (owner == OWN_DMEM) ? dmem_strb  : imem_strb;
        bus_addr  = (owner == OWN_DMEM) ? dmem_addr  : imem_addr;
        bus_wdata = (owner == OWN_DMEM) ? dmem_wdata : imem_wdata;

        push     = bus_req && bus_gnt;
        imem_gnt = push && (owner == OWN_IMEM);
        dmem_gnt = push && (owner == OWN_DMEM);
    end

    // Response routing
    always_comb begin
        fifo_empty = (count_q == '0);
        head_owner = fifo_q[head_q];

        // A response with nothing outstanding is a protocol violation: it is
        // neither routed nor acknowledged and leaves the state untouched.
        imem_recv = bus_recv && !fifo_empty && (head_owner == OWN_IMEM);
        dmem_recv = bus_recv && !fifo_empty && (head_owner == OWN_DMEM);
        bus_ack   = !fifo_empty && ((head_owner == OWN_DMEM) ? dmem_ack : imem_ack);
        pop       = bus_recv && bus_ack;

        imem_error = bus_error;
        dmem_error = bus_error;
        imem_rdata = bus_rdata;
        dmem_rdata = bus_rdata;

        head_nxt = (head_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : head_q + 1'b1;
        tail_nxt = (tail_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : tail_q + 1'b1;
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            lock_valid_q <= 1'b0;
            lock_owner_q <= OWN_IMEM;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++)
                fifo_q[i] <= OWN_IMEM;
`ifdef FRV_MEM_ARBITER_ROUND_ROBIN_EN
            rr_pref_q    <= OWN_IMEM;
`endif
        end else begin
            if (push) begin
                lock_valid_q <= 1'b0;
            end else if (bus_req) begin
                lock_valid_q <= 1'b1;
                lock_owner_q <= owner;
            end

            if (push) begin
                fifo_q[tail_q] <= owner;
                tail_q         <= tail_nxt;
            end
            if (pop)
                head_q <= head_nxt;

            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);

`ifdef FRV_MEM_ARBITER_ROUND_ROBIN_EN
            if (push)
                rr_pref_q <= (owner == OWN_DMEM) ? OWN_IMEM : OWN_DMEM;
`endif
        end
    end

endmodule

// File: tb/tb_frv_mem_arbiter.sv
module tb_frv_mem_arbiter;

    localparam int unsigned MAXO = 4;

`ifdef FRV_MEM_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        imem_req, imem_wen, imem_ack;
    logic [3:0]  imem_strb;
    logic [31:0] imem_addr, imem_wdata;
    logic        imem_gnt, imem_recv, imem_error;
    logic [31:0] imem_rdata;
    logic        dmem_req, dmem_wen, dmem_ack;
    logic [3:0]  dmem_strb;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_gnt, dmem_recv, dmem_error;
    logic [31:0] dmem_rdata;
    logic        bus_req, bus_wen, bus_ack;
    logic [3:0]  bus_strb;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_gnt, bus_recv, bus_error;
    logic [31:0] bus_rdata;

    int total = 0;
    int bad   = 0;

    frv_mem_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .imem_req(imem_req), .imem_wen(imem_wen), .imem_strb(imem_strb),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_gnt(imem_gnt),
        .imem_recv(imem_recv), .imem_ack(imem_ack), .imem_error(imem_error),
        .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_recv(dmem_recv), .dmem_ack(dmem_ack), .dmem_error(dmem_error),
        .dmem_rdata(dmem_rdata),
        .bus_req(bus_req), .bus_wen(bus_wen), .bus_strb(bus_strb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
        .bus_recv(bus_recv), .bus_ack(bus_ack), .bus_error(bus_error),
        .bus_rdata(bus_rdata)
    );

    always #5 g_clk = ~g_clk;

    task automatic idle_inputs();
        imem_req = 0; imem_wen = 0; imem_strb = '0; imem_addr = '0; imem_wdata = '0; imem_ack = 0;
        dmem_req = 0; dmem_wen = 0; dmem_strb = '0; dmem_addr = '0; dmem_wdata = '0; dmem_ack = 0;
        bus_gnt = 0; bus_recv = 0; bus_error = 0; bus_rdata = '0;
    endtask

    // Inputs change 1 time unit after the rising edge; checks sample 3 later.
    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        g_reset = 1;
        tick();
        tick();
        g_reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        g_reset = 1;
        tick();
        #3;
        total++;
        if ({bus_req, imem_gnt, dmem_gnt, imem_recv, dmem_recv, bus_ack} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {bus_req, imem_gnt, dmem_gnt, imem_recv, dmem_recv, bus_ack});
        end
        tick();
        g_reset = 0;
        // Response with empty FIFO: violation, not routed, not acked.
        bus_recv = 1; imem_ack = 1; dmem_ack = 1;
        #3;
        total++;
        if ({imem_recv, dmem_recv, bus_ack} !== 3'b0) begin
            bad++;
            $display("FAIL empty_recv: got %b want 000", {imem_recv, dmem_recv, bus_ack});
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_single();
        do_reset();
        imem_req = 1; imem_addr = 32'h8000_0000; bus_gnt = 1;
        #3;
        total++;
        if (bus_req !== 1 || bus_addr !== 32'h8000_0000 || imem_gnt !== 1 || dmem_gnt !== 0) begin
            bad++;
            $display("FAIL single_req: got req=%b addr=%h ig=%b dg=%b want 1 80000000 1 0",
                     bus_req, bus_addr, imem_gnt, dmem_gnt);
        end
        tick();
        imem_req = 0; bus_gnt = 0;
        bus_recv = 1; bus_rdata = 32'h1234_5678; imem_ack = 1;
        #3;
        total++;
        if (imem_recv !== 1 || dmem_recv !== 0 || bus_ack !== 1 || imem_rdata !== 32'h1234_5678) begin
            bad++;
            $display("FAIL single_resp: got ir=%b dr=%b ack=%b rd=%h want 1 0 1 12345678",
                     imem_recv, dmem_recv, bus_ack, imem_rdata);
        end
        tick();
        // Count back to 0: a further response is an empty-FIFO violation.
        #3;
        total++;
        if (bus_ack !== 0 || imem_recv !== 0) begin
            bad++;
            $display("FAIL single_drained: got ack=%b ir=%b want 0 0", bus_ack, imem_recv);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_lock();
        bit exp_dmem;
        do_reset();
        exp_dmem = !RR;  // round-robin starts favouring imem
        imem_req = 1; imem_addr = 32'h0000_1000;
        dmem_req = 1; dmem_addr = 32'h0000_2000;
        for (int c = 0; c < 3; c++) begin
            #3;
            total++;
            if (bus_req !== 1 || bus_addr !== (exp_dmem ? 32'h2000 : 32'h1000) ||
                imem_gnt !== 0 || dmem_gnt !== 0) begin
                bad++;
                $display("FAIL lock_hold%0d: got req=%b addr=%h ig=%b dg=%b", c, bus_req, bus_addr, imem_gnt, dmem_gnt);
            end
            tick();
        end
        bus_gnt = 1;
        #3;
        total++;
        if (dmem_gnt !== exp_dmem || imem_gnt !== !exp_dmem) begin
            bad++;
            $display("FAIL lock_gnt: got ig=%b dg=%b want %b %b", imem_gnt, dmem_gnt, !exp_dmem, exp_dmem);
        end
        tick();

        // Lock onto imem, then dmem arrives during the stall.
        do_reset();
        imem_req = 1; imem_addr = 32'h0000_3000; dmem_addr = 32'h0000_4000;
        tick();
        dmem_req = 1;
        for (int c = 0; c < 2; c++) begin
            #3;
            total++;
            if (bus_req !== 1 || bus_addr !== 32'h3000) begin
                bad++;
                $display("FAIL lock_imem%0d: got req=%b addr=%h want 1 00003000", c, bus_req, bus_addr);
            end
            tick();
        end
        bus_gnt = 1;
        #3;
        total++;
        if (imem_gnt !== 1 || dmem_gnt !== 0) begin
            bad++;
            $display("FAIL lock_imem_gnt: got ig=%b dg=%b want 1 0", imem_gnt, dmem_gnt);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_full();
        do_reset();
        imem_req = 1; bus_gnt = 1;
        for (int c = 0; c < 4; c++) begin
            imem_addr = 32'h100 + 32'(c) * 4;
            #3;
            total++;
            if (imem_gnt !== 1) begin
                bad++;
                $display("FAIL full_fill%0d: got ig=%b want 1", c, imem_gnt);
            end
            tick();
        end
        #3;
        total++;
        if (bus_req !== 0 || imem_gnt !== 0) begin
            bad++;
            $display("FAIL full_block: got req=%b ig=%b want 0 0", bus_req, imem_gnt);
        end
        tick();
        bus_recv = 1; imem_ack = 1;
        #3;
        total++;
        if (bus_req !== 1 || imem_gnt !== 1 || imem_recv !== 1) begin
            bad++;
            $display("FAIL full_pop_push: got req=%b ig=%b ir=%b want 1 1 1", bus_req, imem_gnt, imem_recv);
        end
        tick();
        bus_recv = 0;
        #3;
        total++;
        if (bus_req !== 0) begin
            bad++;
            $display("FAIL full_still4: got req=%b want 0", bus_req);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_order();
        do_reset();
        bus_gnt = 1;
        imem_req = 1; tick();
        imem_req = 0; dmem_req = 1; tick();
        dmem_req = 0; imem_req = 1; tick();
        imem_req = 0; bus_gnt = 0;
        bus_recv = 1; imem_ack = 1; dmem_ack = 0;
        #3;
        total++;
        if ({imem_recv, dmem_recv, bus_ack} !== 3'b101) begin
            bad++;
            $display("FAIL order_r0: got %b want 101", {imem_recv, dmem_recv, bus_ack});
        end
        tick();
        for (int c = 0; c < 2; c++) begin
            #3;
            total++;
            if ({imem_recv, dmem_recv, bus_ack} !== 3'b010) begin
                bad++;
                $display("FAIL order_stall%0d: got %b want 010", c, {imem_recv, dmem_recv, bus_ack});
            end
            tick();
        end
        dmem_ack = 1;
        #3;
        total++;
        if ({imem_recv, dmem_recv, bus_ack} !== 3'b011) begin
            bad++;
            $display("FAIL order_r1: got %b want 011", {imem_recv, dmem_recv, bus_ack});
        end
        tick();
        dmem_ack = 0;
        #3;
        total++;
        if ({imem_recv, dmem_recv, bus_ack} !== 3'b101) begin
            bad++;
            $display("FAIL order_r2: got %b want 101", {imem_recv, dmem_recv, bus_ack});
        end
        tick();
        #3;
        total++;
        if (bus_ack !== 0) begin
            bad++;
            $display("FAIL order_empty: got ack=%b want 0", bus_ack);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_priority();
        bit exp_dmem;
        do_reset();
        imem_req = 1; dmem_req = 1; bus_gnt = 1;
        for (int c = 0; c < 4; c++) begin
            exp_dmem = RR ? bit'(c % 2) : 1'b1;
            #3;
            total++;
            if (dmem_gnt !== exp_dmem || imem_gnt !== !exp_dmem) begin
                bad++;
                $display("FAIL prio%0d: got ig=%b dg=%b want %b %b", c, imem_gnt, dmem_gnt, !exp_dmem, exp_dmem);
            end
            tick();
        end
        idle_inputs();
    endtask

    // Reference model: transaction-level queue of owners plus the pending
    // (stalled) requester; outputs derived from the arbitration rules.
    task automatic test_random();
        bit q[$];
        bit lock_v, lock_o, pref, pop_e, own, req_e, push_e, both;
        do_reset();
        lock_v = 0; lock_o = 0; pref = 0;
        for (int c = 0; c < 600; c++) begin
            if (c == 300) begin
                do_reset();
                q.delete(); lock_v = 0; pref = 0;
            end
            if (!(lock_v && !lock_o)) begin
                imem_req = 1'($urandom); imem_wen = 1'($urandom); imem_strb = 4'($urandom);
                imem_addr = $urandom; imem_wdata = $urandom;
            end
            if (!(lock_v && lock_o)) begin
                dmem_req = 1'($urandom); dmem_wen = 1'($urandom); dmem_strb = 4'($urandom);
                dmem_addr = $urandom; dmem_wdata = $urandom;
            end
            imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
            bus_gnt = 1'($urandom); bus_recv = 1'($urandom);
            bus_error = 1'($urandom); bus_rdata = $urandom;

            pop_e = bus_recv && q.size() > 0 && (q[0] ? dmem_ack : imem_ack);
            both  = imem_req && dmem_req;
            if (lock_v)            own = lock_o;
            else if (RR && both)   own = pref;
            else                   own = dmem_req;
            req_e = own ? dmem_req : imem_req;
            if (!lock_v && !(q.size() < MAXO || pop_e)) req_e = 0;
            push_e = req_e && bus_gnt;

            #3;
            total++;
            if (bus_req !== req_e || imem_gnt !== (push_e && !own) || dmem_gnt !== (push_e && own)) begin
                bad++;
                $display("FAIL rnd_req c=%0d: got req=%b ig=%b dg=%b want %b %b %b",
                         c, bus_req, imem_gnt, dmem_gnt, req_e, push_e && !own, push_e && own);
            end
            if (req_e) begin
                total++;
                if (bus_addr !== (own ? dmem_addr : imem_addr) || bus_wdata !== (own ? dmem_wdata : imem_wdata) ||
                    bus_wen !== (own ? dmem_wen : imem_wen) || bus_strb !== (own ? dmem_strb : imem_strb)) begin
                    bad++;
                    $display("FAIL rnd_fields c=%0d: got addr=%h want %h", c, bus_addr, own ? dmem_addr : imem_addr);
                end
            end
            total++;
            if (imem_recv !== (bus_recv && q.size() > 0 && !q[0]) ||
                dmem_recv !== (bus_recv && q.size() > 0 && q[0]) ||
                bus_ack !== (q.size() > 0 && (q[0] ? dmem_ack : imem_ack))) begin
                bad++;
                $display("FAIL rnd_resp c=%0d: got ir=%b dr=%b ack=%b qsize=%0d", c, imem_recv, dmem_recv, bus_ack, q.size());
            end
            if (bus_recv) begin
                total++;
                if (imem_rdata !== bus_rdata || dmem_rdata !== bus_rdata ||
                    imem_error !== bus_error || dmem_error !== bus_error) begin
                    bad++;
                    $display("FAIL rnd_data c=%0d: got %h/%h want %h", c, imem_rdata, dmem_rdata, bus_rdata);
                end
            end

            if (pop_e) void'(q.pop_front());
            if (push_e) begin
                q.push_back(own);
                lock_v = 0;
                pref = !own;
            end else if (req_e) begin
                lock_v = 1;
                lock_o = own;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        g_reset = 1;
        test_reset();
        test_single();
        test_lock();
        test_full();
        test_order();
        test_priority();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
